// File: rtl/sprite_motion_ctrl.sv
// Frame-synchronous player motion: debounced switches, accelerating step, wall clamp.
// Latency: o_x/o_y/updated change on the 5th edge after VS falls; no backpressure (free-running).
module sprite_motion_ctrl #(
  parameter int X_INIT       = 320,
  parameter int Y_INIT       = 240,
  parameter int SIZE         = 30,
  parameter int X_MIN        = 10,
  parameter int X_MAX        = 630,
  parameter int Y_MIN        = 10,
  parameter int Y_MAX        = 470,
  parameter int DEB_CYCLES   = 500000,
  parameter int ACCEL_FRAMES = 8,
  parameter int MAX_STEP     = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       VS,
  input  logic       up_switch,
  input  logic       dn_switch,
  input  logic       left_switch,
  input  logic       right_switch,
  output logic [9:0] o_x,
  output logic [9:0] o_y,
  output logic [3:0] step,
  output logic [3:0] wall_hit,
  output logic       updated
);

  localparam int DCW = $clog2(DEB_CYCLES);
  localparam int HCW = $clog2(ACCEL_FRAMES + 1);
  localparam logic [10:0] X_LO = 11'(X_MIN);
  localparam logic [10:0] X_HI = 11'(X_MAX - SIZE);
  localparam logic [10:0] Y_LO = 11'(Y_MIN);
  localparam logic [10:0] Y_HI = 11'(Y_MAX - SIZE);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_COMMIT} state_t;

  typedef struct packed {
    logic x_neg;
    logic x_pos;
    logic y_neg;
    logic y_pos;
  } dir_t;

  typedef struct packed {
    logic       lo_hit;
    logic       hi_hit;
    logic [9:0] pos;
  } axis_t;

  // Switch bit order: {up, dn, left, right}
  logic [3:0]     sw_s1, sw_s2, sw_stable;
  logic [DCW-1:0] deb_cnt [4];
  logic           vs_s1, vs_s2, vs_prev, vs_fall;
  logic [3:0]     pressed;
  dir_t           dir_d, dir_q;
  state_t         state, state_nxt;
  logic           snap_en, calc_en, commit_en;
  axis_t          ax, ay;
  logic [9:0]     nx_q, ny_q;
  logic [3:0]     wall_q;
  logic [HCW-1:0] hold_cnt;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sw_s1   <= 4'hF;
      sw_s2   <= 4'hF;
      vs_s1   <= 1'b1;
      vs_s2   <= 1'b1;
      vs_prev <= 1'b1;
    end else begin
      sw_s1   <= {up_switch, dn_switch, left_switch, right_switch};
      sw_s2   <= sw_s1;
      vs_s1   <= VS;
      vs_s2   <= vs_s1;
      vs_prev <= vs_s2;
    end
  end

  assign vs_fall = vs_prev & ~vs_s2;

  // Accept a new level only after DEB_CYCLES consecutive disagreeing samples
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sw_stable <= 4'hF;
      for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sw_s2[i] == sw_stable[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DCW'(DEB_CYCLES - 1)) begin
          sw_stable[i] <= sw_s2[i];
          deb_cnt[i]   <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DCW'(1);
        end
      end
    end
  end

  assign pressed     = ~sw_stable;
  assign dir_d.x_neg = pressed[1] & ~pressed[0];
  assign dir_d.x_pos = pressed[0] & ~pressed[1];
  assign dir_d.y_neg = pressed[3] & ~pressed[2];
  assign dir_d.y_pos = pressed[2] & ~pressed[3];

  always_ff @(posedge CLK) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (vs_fall) state_nxt = S_CALC;
      S_CALC:   state_nxt = S_COMMIT;
      S_COMMIT: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    snap_en   = 1'b0;
    calc_en   = 1'b0;
    commit_en = 1'b0;
    case (state)
      S_IDLE:   snap_en   = vs_fall;
      S_CALC:   calc_en   = 1'b1;
      S_COMMIT: commit_en = 1'b1;
      default:  ;
    endcase
  end

  function automatic axis_t axis_move(input logic [10:0] cur, input logic [10:0] stp,
                                      input logic [10:0] lo, input logic [10:0] hi,
                                      input logic mv_neg, input logic mv_pos);
    axis_t r;
    r.lo_hit = 1'b0;
    r.hi_hit = 1'b0;
    r.pos    = cur[9:0];
    if (mv_neg) begin
      if (cur < lo + stp) begin
        r.pos    = lo[9:0];
        r.lo_hit = 1'b1;
      end else begin
        r.pos = 10'(cur - stp);
      end
    end else if (mv_pos) begin
      if (cur + stp > hi) begin
        r.pos    = hi[9:0];
        r.hi_hit = 1'b1;
      end else begin
        r.pos = 10'(cur + stp);
      end
    end
    return r;
  endfunction

  assign ax = axis_move({1'b0, o_x}, {7'd0, step}, X_LO, X_HI, dir_q.x_neg, dir_q.x_pos);
  assign ay = axis_move({1'b0, o_y}, {7'd0, step}, Y_LO, Y_HI, dir_q.y_neg, dir_q.y_pos);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      dir_q    <= '0;
      nx_q     <= 10'(X_INIT);
      ny_q     <= 10'(Y_INIT);
      wall_q   <= '0;
      o_x      <= 10'(X_INIT);
      o_y      <= 10'(Y_INIT);
      wall_hit <= '0;
      step     <= 4'd1;
      hold_cnt <= '0;
      updated  <= 1'b0;
    end else begin
      updated <= commit_en;
      if (snap_en) dir_q <= dir_d;
      if (calc_en) begin
        nx_q   <= ax.pos;
        ny_q   <= ay.pos;
        wall_q <= {ax.lo_hit, ax.hi_hit, ay.lo_hit, ay.hi_hit};
      end
      if (commit_en) begin
        o_x      <= nx_q;
        o_y      <= ny_q;
        wall_hit <= wall_q;
        // Speed ramps only while some direction is held; any idle frame drops it back to 1
        if (dir_q != '0) begin
          if (hold_cnt == HCW'(ACCEL_FRAMES - 1)) begin
            hold_cnt <= '0;
            if (step < 4'(MAX_STEP)) step <= step + 4'd1;
          end else begin
            hold_cnt <= hold_cnt + HCW'(1);
          end
        end else begin
          step     <= 4'd1;
          hold_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed bench for sprite_motion_ctrl with short debounce and fast acceleration.
module tb_sprite_motion_ctrl;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       VS = 1'b1;
  logic       up_switch = 1'b1;
  logic       dn_switch = 1'b1;
  logic       left_switch = 1'b1;
  logic       right_switch = 1'b1;
  logic [9:0] o_x, o_y;
  logic [3:0] step, wall_hit;
  logic       updated;

  int n_chk = 0;
  int n_fail = 0;
  int upd_cnt = 0;
  int u0;
  int exp_x[6] = '{322, 324, 326, 329, 332, 335};

  sprite_motion_ctrl #(
    .DEB_CYCLES  (4),
    .ACCEL_FRAMES(2),
    .MAX_STEP    (3)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .VS          (VS),
    .up_switch   (up_switch),
    .dn_switch   (dn_switch),
    .left_switch (left_switch),
    .right_switch(right_switch),
    .o_x         (o_x),
    .o_y         (o_y),
    .step        (step),
    .wall_hit    (wall_hit),
    .updated     (updated)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (updated === 1'b1) upd_cnt++;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic frame();
    @(posedge CLK);
    #1 VS = 1'b0;
    tick(6);
    VS = 1'b1;
    tick(4);
  endtask

  initial begin
    tick(3);
    RST_N = 1'b1;
    chk("rst_x", o_x, 320);
    chk("rst_y", o_y, 240);
    chk("rst_step", step, 1);
    chk("rst_wall", wall_hit, 0);
    chk("rst_upd", updated, 0);

    u0 = upd_cnt;
    repeat (3) frame();
    chk("idle_upd_count", upd_cnt - u0, 3);
    chk("idle_x", o_x, 320);
    chk("idle_y", o_y, 240);

    // Latency from VS pin fall, first right frame
    right_switch = 1'b0;
    tick(10);
    @(posedge CLK);
    #1 VS = 1'b0;
    tick(4);
    chk("lat_e4_upd", updated, 0);
    chk("lat_e4_x", o_x, 320);
    tick(1);
    chk("lat_e5_upd", updated, 1);
    chk("lat_e5_x", o_x, 321);
    chk("lat_e5_y", o_y, 240);
    tick(1);
    chk("lat_e6_upd", updated, 0);
    VS = 1'b1;
    tick(4);

    for (int i = 0; i < 6; i++) begin
      frame();
      chk("accel_x", o_x, exp_x[i]);
    end
    chk("accel_step_sat", step, 3);
    chk("accel_wall", wall_hit, 0);

    // Left wall: 335 - 3*108 = 11, then clamp at 10
    right_switch = 1'b1;
    left_switch  = 1'b0;
    tick(10);
    repeat (108) frame();
    chk("left_x_pre", o_x, 11);
    chk("left_wall_pre", wall_hit, 0);
    chk("left_y", o_y, 240);
    frame();
    chk("left_x_clamp", o_x, 10);
    chk("left_wall_clamp", wall_hit, 4'b1000);
    frame();
    chk("left_x_hold", o_x, 10);
    chk("left_wall_hold", wall_hit, 4'b1000);

    left_switch = 1'b1;
    up_switch   = 1'b0;
    dn_switch   = 1'b0;
    tick(10);
    for (int i = 0; i < 4; i++) begin
      frame();
      chk("updn_y", o_y, 240);
      chk("updn_step", step, 1);
    end
    chk("updn_x", o_x, 10);
    chk("updn_wall", wall_hit, 0);

    dn_switch = 1'b1;
    tick(10);
    frame();
    chk("up_y1", o_y, 239);
    frame();
    chk("up_y2", o_y, 238);
    chk("up_step", step, 2);

    // Two-cycle glitch on right straddling the VS fall
    up_switch = 1'b1;
    tick(10);
    @(posedge CLK);
    #1 right_switch = 1'b0;
    tick(1);
    VS = 1'b0;
    tick(1);
    right_switch = 1'b1;
    tick(5);
    VS = 1'b1;
    tick(4);
    chk("glitch_x", o_x, 10);
    chk("glitch_y", o_y, 238);
    chk("glitch_wall", wall_hit, 0);

    // Reset pulse while the FSM sits in CALC
    right_switch = 1'b0;
    tick(10);
    @(posedge CLK);
    #1 VS = 1'b0;
    tick(3);
    RST_N        = 1'b0;
    VS           = 1'b1;
    right_switch = 1'b1;
    u0 = upd_cnt;
    tick(1);
    RST_N = 1'b1;
    tick(8);
    chk("midrst_upd_count", upd_cnt - u0, 0);
    chk("midrst_x", o_x, 320);
    chk("midrst_y", o_y, 240);
    chk("midrst_step", step, 1);
    chk("midrst_wall", wall_hit, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
